multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Moore-style main controller for the multi-cycle RV32I core. It sequences the shared ALU, the unified instruction/data memory port, the IR/MDR/ALUOut latches and the register file through the states fetch, decode, execute, memory, writeback, PC-increment and halt. The block drives `alu_ctrl_op` into the existing ALU control unit, which still performs funct3/funct7 decode. It waits on a memory-ready handshake for every memory access.

## Interface
- `IMEM_WAIT_MAX`, default 0: 0 means no timeout. A nonzero value is a debug bound; the FSM reports `mem_timeout` after this many consecutive not-ready cycles.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on rising edge of `clk`.
- `opcode`  in  7  IR[6:0]; valid from ID onward.
- `alu_bcond`  in  1  branch-condition result from the ALU; sampled in EX of branches.
- `mem_ready`  in  1  memory completes the current read/write this cycle.
- `halt_req`  in  1  register x17 == 10; sampled in ID of ECALL.
- `ir_write`  out  1  latch memory data into IR.
- `i_or_d`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `mem_read`, `mem_write`  out  1 each  memory strobes.
- `mem_to_reg`  out  1  rd source: 0 = ALUOut, 1 = MDR.
- `reg_write`  out  1  register file write enable.
- `alu_src_a`  out  1  0 = PC, 1 = rs1.
- `alu_src_b`  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- `alu_ctrl_op`  out  2  00 = add, 01 = branch compare, 10 = funct decode.
- `pc_write`  out  1  PC update enable.
- `pc_source`  out  1  0 = live ALU result, 1 = ALUOut.
- `is_halted`  out  1  core halted.
- `mem_timeout`  out  1  sticky debug flag; cleared only by reset.

## Operation
- State register: 4 bits. Outputs decode combinationally from the state only, except for the qualified strobes listed below.
- Any output not listed for a state is 0.
- **IF**
  - Outputs: `mem_read`=1, `i_or_d`=0, `ir_write`=`mem_ready`.
  - Next state: ID if `mem_ready`, else stay in IF.
- **ID**
  - Outputs: ALU computes PC+imm into ALUOut (`alu_src_a`=0, `alu_src_b`=10, op 00).
  - Next state: ECALL with `halt_req` → HALT. ECALL without `halt_req` → PCINC. All other opcodes → EX.
- **EX**, by opcode:
  - R-type: `alu_src_a`=1, `alu_src_b`=00, op 10. Next WB.
  - I-arith: `alu_src_a`=1, `alu_src_b`=10, op 10. Next WB.
  - LOAD/STORE: `alu_src_a`=1, `alu_src_b`=10, op 00. Next MEM.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, op 01. If `alu_bcond`: `pc_write`=1, `pc_source`=1, next IF. Otherwise next PCINC.
  - JAL/JALR: PC+4 into ALUOut (`alu_src_a`=0, `alu_src_b`=01, op 00). Next JWB.
  - Unknown opcode: next PCINC (executes as a nop).
- **MEM**
  - Outputs: `i_or_d`=1. `mem_read`=1 for LOAD, `mem_write`=1 for STORE. Both strobes stay held until `mem_ready`.
  - Next state: LOAD → WB, STORE → PCINC (only once `mem_ready`).
- **WB**
  - Outputs: `reg_write`=1, `mem_to_reg`=(opcode==LOAD). ALU computes PC+4 (`alu_src_a`=0, `alu_src_b`=01, op 00) with `pc_write`=1, `pc_source`=0.
  - Next state: IF.
- **JWB**
  - Outputs: `reg_write`=1, `mem_to_reg`=0. ALU computes the target: JAL uses PC+imm (`alu_src_a`=0); JALR uses rs1+imm (`alu_src_a`=1); `alu_src_b`=10, op 00. `pc_write`=1, `pc_source`=0.
  - Next state: IF.
- **PCINC**
  - Outputs: PC+4 with `pc_write`=1, `pc_source`=0.
  - Next state: IF.
- **HALT**
  - Absorbing state; only reset leaves it. `is_halted`=1; all strobes 0.
- Timeout: the wait counter counts consecutive not-ready cycles in IF/MEM and clears when `mem_ready` is seen. When the count reaches `IMEM_WAIT_MAX` (nonzero), `mem_timeout` sets. The FSM keeps waiting.

## Timing
- Reset:
  - State becomes IF and `mem_timeout` clears.
  - Reset values after the edge: `mem_read`=1, all other outputs 0.
  - While `reset` is high, `ir_write`, `mem_write`, `reg_write` and `pc_write` are forced to 0. A mid-MEM store or mid-WB write therefore never commits during the reset cycle.
- Latency with `mem_ready` always 1:
  - R/I-arith: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 5 cycles.
  - Taken branch: 3 cycles.
  - Not-taken branch: 4 cycles.
  - JAL/JALR: 4 cycles.
  - ECALL (no halt): 3 cycles.
- Each not-ready cycle in IF or MEM adds exactly 1 cycle.
- `alu_bcond` and `halt_req` are sampled only in their respective states and ignored elsewhere.

## Structure
- State encodings (IF=0, ID=1, EX=2, MEM=3, WB=4, JWB=5, PCINC=6, HALT=7) and the `alu_src_b`/`alu_ctrl_op` encodings go in the shared header `multicycle_defs.v`, next to `opcodes.v`.
- Opcode constants come from `opcodes.v`.
- Natural sub-module: `mc_output_decoder`, a purely combinational mapping from (state, opcode, alu_bcond, mem_ready) to control outputs. The top level holds the state register, next-state logic, wait counter and reset gating.

## Test plan
- R-type ADD with `mem_ready`=1: state sequence IF,ID,EX,WB,IF. In WB, `reg_write`=1, `mem_to_reg`=0, `pc_write`=1.
- LOAD with `mem_ready` low for 2 cycles in MEM: MEM lasts 3 cycles with `mem_read`=1 and `i_or_d`=1, followed by WB with `mem_to_reg`=1. Total 7 cycles.
- BEQ with `alu_bcond`=1: in EX, `pc_write`=1 and `pc_source`=1, then IF (3 cycles). With `alu_bcond`=0: EX→PCINC→IF (4 cycles).
- JALR: in JWB, `reg_write`=1, `alu_src_a`=1, `alu_src_b`=10, `pc_write`=1.
- ECALL with `halt_req`=1: ID→HALT with `is_halted`=1, which stays 1 for 20 cycles. Reset then returns to IF with `is_halted`=0.
- Reset asserted during a STORE's MEM cycle: `mem_write`=0 in that cycle and state=IF on the next cycle. With `IMEM_WAIT_MAX`=4 and `mem_ready` held low in IF, `mem_timeout`=1 after 4 cycles.

Source files
------------

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller: opcodes, FSM
// states, ALU operand/op selects and the bundled control-word type.
package multicycle_control_fsm_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_IARITH = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    S_IF    = 4'd0,
    S_ID    = 4'd1,
    S_EX    = 4'd2,
    S_MEM   = 4'd3,
    S_WB    = 4'd4,
    S_JWB   = 4'd5,
    S_PCINC = 4'd6,
    S_HALT  = 4'd7
  } state_t;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;

  typedef struct packed {
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_ctrl_op;
    logic       pc_write;
    logic       pc_source;
    logic       is_halted;
  } ctrl_t;

endpackage

// File: rtl/mc_output_decoder.sv
// Purely combinational control-word decode from the current FSM state plus
// the few inputs that qualify individual strobes.
module mc_output_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  state_t     state_i,
  input  logic [6:0] opcode_i,
  input  logic       alu_bcond_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_IF: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.ir_write = mem_ready_i;
      end
      // Speculatively form the branch/JAL target while the opcode is decoded.
      S_ID: begin
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      S_EX: begin
        case (opcode_i)
          OP_RTYPE: begin
            ctrl_o.alu_src_a   = 1'b1;
            ctrl_o.alu_ctrl_op = ALUOP_FUNCT;
          end
          OP_IARITH: begin
            ctrl_o.alu_src_a   = 1'b1;
            ctrl_o.alu_src_b   = SRCB_IMM;
            ctrl_o.alu_ctrl_op = ALUOP_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            ctrl_o.alu_src_a = 1'b1;
            ctrl_o.alu_src_b = SRCB_IMM;
          end
          OP_BRANCH: begin
            ctrl_o.alu_src_a   = 1'b1;
            ctrl_o.alu_ctrl_op = ALUOP_BRANCH;
            ctrl_o.pc_write    = alu_bcond_i;
            ctrl_o.pc_source   = alu_bcond_i;
          end
          OP_JAL, OP_JALR: begin
            ctrl_o.alu_src_b = SRCB_FOUR;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        ctrl_o.i_or_d    = 1'b1;
        ctrl_o.mem_read  = (opcode_i == OP_LOAD);
        ctrl_o.mem_write = (opcode_i == OP_STORE);
      end
      S_WB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = (opcode_i == OP_LOAD);
        ctrl_o.alu_src_b  = SRCB_FOUR;
        ctrl_o.pc_write   = 1'b1;
      end
      // Link value already sits in ALUOut; the live ALU result is the jump target.
      S_JWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.alu_src_a = (opcode_i == OP_JALR);
        ctrl_o.alu_src_b = SRCB_IMM;
        ctrl_o.pc_write  = 1'b1;
      end
      S_PCINC: begin
        ctrl_o.alu_src_b = SRCB_FOUR;
        ctrl_o.pc_write  = 1'b1;
      end
      S_HALT: begin
        ctrl_o.is_halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main controller for the multi-cycle RV32I core: state register, next-state
// logic, memory wait/timeout tracking and reset gating of commit strobes.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned IMEM_WAIT_MAX = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  input  logic       halt_req,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_ctrl_op,
  output logic       pc_write,
  output logic       pc_source,
  output logic       is_halted,
  output logic       mem_timeout
);

  localparam int unsigned CntW = (IMEM_WAIT_MAX > 0) ? $clog2(IMEM_WAIT_MAX + 1) : 1;

  state_t          state_q, state_d;
  logic [CntW-1:0] waitCnt_q, waitCnt_d;
  logic            timeout_q, timeout_d;
  ctrl_t           ctrl;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IF:  if (mem_ready) state_d = S_ID;
      S_ID: begin
        if (opcode == OP_SYSTEM) state_d = halt_req ? S_HALT : S_PCINC;
        else                     state_d = S_EX;
      end
      S_EX: begin
        case (opcode)
          OP_RTYPE, OP_IARITH: state_d = S_WB;
          OP_LOAD, OP_STORE:   state_d = S_MEM;
          OP_BRANCH:           state_d = alu_bcond ? S_IF : S_PCINC;
          OP_JAL, OP_JALR:     state_d = S_JWB;
          default:             state_d = S_PCINC;
        endcase
      end
      S_MEM: if (mem_ready) state_d = (opcode == OP_LOAD) ? S_WB : S_PCINC;
      S_WB, S_JWB, S_PCINC: state_d = S_IF;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Counter saturates at the bound; the flag stays set while the FSM keeps waiting.
  always_comb begin
    waitCnt_d = waitCnt_q;
    timeout_d = timeout_q;
    if ((state_q == S_IF) || (state_q == S_MEM)) begin
      if (mem_ready) begin
        waitCnt_d = '0;
      end else if (IMEM_WAIT_MAX != 0) begin
        if (waitCnt_q != CntW'(IMEM_WAIT_MAX)) waitCnt_d = waitCnt_q + CntW'(1);
        if (waitCnt_q == CntW'(IMEM_WAIT_MAX - 1)) timeout_d = 1'b1;
      end
    end else begin
      waitCnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IF;
      waitCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      waitCnt_q <= waitCnt_d;
      timeout_q <= timeout_d;
    end
  end

  mc_output_decoder u_decoder (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .alu_bcond_i (alu_bcond),
    .mem_ready_i (mem_ready),
    .ctrl_o      (ctrl)
  );

  // Architectural commits are suppressed during the reset cycle itself.
  assign ir_write    = ctrl.ir_write  & ~reset;
  assign mem_write   = ctrl.mem_write & ~reset;
  assign reg_write   = ctrl.reg_write & ~reset;
  assign pc_write    = ctrl.pc_write  & ~reset;
  assign i_or_d      = ctrl.i_or_d;
  assign mem_read    = ctrl.mem_read;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign alu_ctrl_op = ctrl.alu_ctrl_op;
  assign pc_source   = ctrl.pc_source;
  assign is_halted   = ctrl.is_halted;
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: directed per-cycle vectors with
// hand-derived control words, checked by a decoupled negedge monitor.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OpR    = 7'b0110011;
  localparam logic [6:0] OpI    = 7'b0010011;
  localparam logic [6:0] OpLd   = 7'b0000011;
  localparam logic [6:0] OpSt   = 7'b0100011;
  localparam logic [6:0] OpBr   = 7'b1100011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpJalr = 7'b1100111;
  localparam logic [6:0] OpSys  = 7'b1110011;
  localparam logic [6:0] OpBad  = 7'b0000000;

  // {ir,iord,mrd,mwr,m2r,rwr,srcA} , srcB , aluOp , {pcWr,pcSrc,halted,timeout}
  localparam logic [14:0] V_IF_RDY  = {7'b1010000, 2'b00, 2'b00, 4'b0000};
  localparam logic [14:0] V_IF_NR   = {7'b0010000, 2'b00, 2'b00, 4'b0000};
  localparam logic [14:0] V_ID      = {7'b0000000, 2'b10, 2'b00, 4'b0000};
  localparam logic [14:0] V_EX_R    = {7'b0000001, 2'b00, 2'b10, 4'b0000};
  localparam logic [14:0] V_EX_I    = {7'b0000001, 2'b10, 2'b10, 4'b0000};
  localparam logic [14:0] V_EX_ADDR = {7'b0000001, 2'b10, 2'b00, 4'b0000};
  localparam logic [14:0] V_EX_BT   = {7'b0000001, 2'b00, 2'b01, 4'b1100};
  localparam logic [14:0] V_EX_BN   = {7'b0000001, 2'b00, 2'b01, 4'b0000};
  localparam logic [14:0] V_EX_J    = {7'b0000000, 2'b01, 2'b00, 4'b0000};
  localparam logic [14:0] V_EX_NOP  = {7'b0000000, 2'b00, 2'b00, 4'b0000};
  localparam logic [14:0] V_MEM_LD  = {7'b0110000, 2'b00, 2'b00, 4'b0000};
  localparam logic [14:0] V_MEM_ST  = {7'b0101000, 2'b00, 2'b00, 4'b0000};
  localparam logic [14:0] V_MEM_STR = {7'b0100000, 2'b00, 2'b00, 4'b0000};
  localparam logic [14:0] V_WB_ALU  = {7'b0000010, 2'b01, 2'b00, 4'b1000};
  localparam logic [14:0] V_WB_LD   = {7'b0000110, 2'b01, 2'b00, 4'b1000};
  localparam logic [14:0] V_WB_RST  = {7'b0000000, 2'b01, 2'b00, 4'b0000};
  localparam logic [14:0] V_JWB_JAL = {7'b0000010, 2'b10, 2'b00, 4'b1000};
  localparam logic [14:0] V_JWB_JR  = {7'b0000011, 2'b10, 2'b00, 4'b1000};
  localparam logic [14:0] V_PCINC   = {7'b0000000, 2'b01, 2'b00, 4'b1000};
  localparam logic [14:0] V_HALT    = {7'b0000000, 2'b00, 2'b00, 4'b0010};

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_bcond, mem_ready, halt_req;
  logic       ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write;
  logic       alu_src_a, pc_write, pc_source, is_halted, mem_timeout;
  logic [1:0] alu_src_b, alu_ctrl_op;

  typedef struct {
    logic [14:0] exp;
    string       tag;
  } expect_t;

  expect_t sbQueue[$];
  int      checkCount = 0;
  int      errorCount = 0;
  logic    expTimeout = 1'b0;

  multicycle_control_fsm #(.IMEM_WAIT_MAX(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .alu_bcond   (alu_bcond),
    .mem_ready   (mem_ready),
    .halt_req    (halt_req),
    .ir_write    (ir_write),
    .i_or_d      (i_or_d),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_ctrl_op (alu_ctrl_op),
    .pc_write    (pc_write),
    .pc_source   (pc_source),
    .is_halted   (is_halted),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs just after the rising edge and queue the control
  // word the DUT must present for that cycle.
  task automatic applyStimulus(input string tag, input logic [6:0] op,
                               input logic rdy, input logic bcond,
                               input logic halt, input logic rst,
                               input logic [14:0] expVec);
    expect_t e;
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = rdy;
    alu_bcond = bcond;
    halt_req  = halt;
    reset     = rst;
    e.exp = {expVec[14:1], expTimeout};
    e.tag = tag;
    sbQueue.push_back(e);
  endtask

  task automatic step(input string tag, input logic [6:0] op, input logic [14:0] expVec);
    applyStimulus(tag, op, 1'b1, 1'b0, 1'b0, 1'b0, expVec);
  endtask

  task automatic checkOutput(input string tag, input logic [14:0] exp);
    logic [14:0] act;
    act = {ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write, alu_src_a,
           alu_src_b, alu_ctrl_op, pc_write, pc_source, is_halted, mem_timeout};
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, act, exp, $time);
    end
  endtask

  // Monitor: consumes one expected word per cycle, away from the active edge.
  always @(negedge clk) begin
    expect_t e;
    if (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      checkOutput(e.tag, e.exp);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1; opcode = OpR; mem_ready = 1'b1; alu_bcond = 1'b0; halt_req = 1'b0;
    repeat (2) @(posedge clk);
    applyStimulus("reset.IF", OpR, 1'b1, 1'b0, 1'b0, 1'b1, V_IF_NR);

    step("r.IF", OpR, V_IF_RDY);   step("r.ID", OpR, V_ID);
    step("r.EX", OpR, V_EX_R);     step("r.WB", OpR, V_WB_ALU);

    step("i.IF", OpI, V_IF_RDY);   step("i.ID", OpI, V_ID);
    step("i.EX", OpI, V_EX_I);     step("i.WB", OpI, V_WB_ALU);

    step("ld.IF", OpLd, V_IF_RDY); step("ld.ID", OpLd, V_ID);
    step("ld.EX", OpLd, V_EX_ADDR);
    applyStimulus("ld.MEMw0", OpLd, 1'b0, 1'b0, 1'b0, 1'b0, V_MEM_LD);
    applyStimulus("ld.MEMw1", OpLd, 1'b0, 1'b0, 1'b0, 1'b0, V_MEM_LD);
    step("ld.MEM", OpLd, V_MEM_LD); step("ld.WB", OpLd, V_WB_LD);

    step("st.IF", OpSt, V_IF_RDY); step("st.ID", OpSt, V_ID);
    step("st.EX", OpSt, V_EX_ADDR); step("st.MEM", OpSt, V_MEM_ST);
    step("st.PCINC", OpSt, V_PCINC);

    step("bt.IF", OpBr, V_IF_RDY); step("bt.ID", OpBr, V_ID);
    applyStimulus("bt.EX", OpBr, 1'b1, 1'b1, 1'b0, 1'b0, V_EX_BT);

    applyStimulus("bn.IF", OpBr, 1'b1, 1'b1, 1'b0, 1'b0, V_IF_RDY);
    applyStimulus("bn.ID", OpBr, 1'b1, 1'b1, 1'b0, 1'b0, V_ID);
    step("bn.EX", OpBr, V_EX_BN);  step("bn.PCINC", OpBr, V_PCINC);

    step("jal.IF", OpJal, V_IF_RDY);  step("jal.ID", OpJal, V_ID);
    step("jal.EX", OpJal, V_EX_J);    step("jal.JWB", OpJal, V_JWB_JAL);
    step("jalr.IF", OpJalr, V_IF_RDY); step("jalr.ID", OpJalr, V_ID);
    step("jalr.EX", OpJalr, V_EX_J);   step("jalr.JWB", OpJalr, V_JWB_JR);

    step("bad.IF", OpBad, V_IF_RDY); step("bad.ID", OpBad, V_ID);
    step("bad.EX", OpBad, V_EX_NOP); step("bad.PCINC", OpBad, V_PCINC);

    applyStimulus("ecall.IF", OpSys, 1'b1, 1'b0, 1'b1, 1'b0, V_IF_RDY);
    step("ecall.ID", OpSys, V_ID);   step("ecall.PCINC", OpSys, V_PCINC);

    step("rwb.IF", OpR, V_IF_RDY);   step("rwb.ID", OpR, V_ID);
    step("rwb.EX", OpR, V_EX_R);
    applyStimulus("rwb.WBreset", OpR, 1'b1, 1'b0, 1'b0, 1'b1, V_WB_RST);

    for (int i = 0; i < 5; i++) begin
      expTimeout = (i == 4);
      applyStimulus("to.IFwait", OpR, 1'b0, 1'b0, 1'b0, 1'b0, V_IF_NR);
    end
    step("to.IF", OpR, V_IF_RDY);    step("to.ID", OpR, V_ID);
    step("to.EX", OpR, V_EX_R);      step("to.WB", OpR, V_WB_ALU);

    step("sr.IF", OpSt, V_IF_RDY);   step("sr.ID", OpSt, V_ID);
    step("sr.EX", OpSt, V_EX_ADDR);
    applyStimulus("sr.MEMreset", OpSt, 1'b1, 1'b0, 1'b0, 1'b1, V_MEM_STR);
    expTimeout = 1'b0;
    step("sr.IF", OpSt, V_IF_RDY);   step("sr.ID", OpSt, V_ID);
    step("sr.EX", OpSt, V_EX_ADDR);  step("sr.MEM", OpSt, V_MEM_ST);
    step("sr.PCINC", OpSt, V_PCINC);

    step("h.IF", OpSys, V_IF_RDY);
    applyStimulus("h.ID", OpSys, 1'b1, 1'b0, 1'b1, 1'b0, V_ID);
    for (int i = 0; i < 20; i++) begin
      applyStimulus("h.HALT", OpR, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                    1'b0, V_HALT);
    end
    applyStimulus("h.reset", OpR, 1'b1, 1'b0, 1'b0, 1'b1, V_HALT);
    step("h.IF", OpR, V_IF_RDY);     step("h.ID", OpR, V_ID);
    step("h.EX", OpR, V_EX_R);       step("h.WB", OpR, V_WB_ALU);

    repeat (2) @(posedge clk);
    checkCount++;
    if (sbQueue.size() != 0) begin
      errorCount++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", sbQueue.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
